// File: rtl/segment_insert_pkg.sv
// Shared definitions for the segment insert scheduler slice.
//
// Holds the default geometry of the scheduler, the width helpers used to
// size the cfg/segment ports from the module parameters, and the packed
// context record {seg, size, sel} that travels from the per-ID table
// through the context FIFO to the inserter configuration outputs.
package segment_insert_pkg;

  localparam int DEF_AXIS_USER_WIDTH  = 4;
  localparam int DEF_MAX_INSRT_SIZE   = 4;
  localparam int DEF_NUM_INSERT_SIZES = 2;
  localparam int DEF_CTX_DEPTH        = 4;

  // Width of a byte count that can hold 0..max_size inclusive.
  function automatic int size_width(input int max_size);
    return $clog2(max_size + 1);
  endfunction

  // Width of the inserter variant select; a single variant still needs
  // one bit so the port never collapses to zero width.
  function automatic int sel_width(input int num_sizes);
    return (num_sizes > 1) ? $clog2(num_sizes) : 1;
  endfunction

  localparam int DEF_SEG_W  = DEF_MAX_INSRT_SIZE * 8;
  localparam int DEF_SIZE_W = size_width(DEF_MAX_INSRT_SIZE);
  localparam int DEF_SEL_W  = sel_width(DEF_NUM_INSERT_SIZES);

  // One packet context: what to insert, how many bytes, which inserter.
  // Field order matches the flattened {seg, size, sel} words used by the
  // table and the FIFO.
  typedef struct packed {
    logic [DEF_SEG_W-1:0]  seg;
    logic [DEF_SIZE_W-1:0] size;
    logic [DEF_SEL_W-1:0]  sel;
  } ctx_t;

  localparam int DEF_CTX_W = $bits(ctx_t);

endpackage

// File: rtl/insert_ctx_fifo.sv
// Context FIFO with a registered head.
//
// Stores one context word per packet in flight. The oldest entry is
// presented on head_data straight from a register, so consumers never see
// a combinational path from push_data. head_data is all-zero whenever the
// FIFO is empty, and an entry pushed into an empty FIFO appears on the
// head one clock later.
//
// Ports:
//   aclk, areset   clock, asynchronous active-high reset (empties the FIFO)
//   push           write push_data this cycle (ignored when full without pop)
//   push_data      context word to store
//   pop            retire the head entry (ignored when empty)
//   head_data      registered oldest entry, zero when empty
//   count          number of stored entries, 0..DEPTH
//   full           count == DEPTH
module insert_ctx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_next;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic             pop_eff;
  logic             push_eff;

  // Explicit wrap keeps the pointers correct even for a depth of one.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign pop_eff    = pop && (count_q != '0);
  assign push_eff   = push && ((count_q != DEPTH_C) || pop_eff);
  assign rd_ptr_inc = ptr_inc(rd_ptr_q);

  // Occupancy after this cycle; a simultaneous push and pop cancel out.
  always_comb begin
    count_next = count_q;
    if (push_eff && !pop_eff) begin
      count_next = count_q + CNT_W'(1);
    end else if (!push_eff && pop_eff) begin
      count_next = count_q - CNT_W'(1);
    end
  end

  // Next head value. When the FIFO empties the head goes to zero; when the
  // only survivor is the word being pushed it is taken from push_data
  // directly, since it is not in memory yet. Otherwise a pop exposes the
  // entry behind the current head, which was written in an earlier cycle.
  always_comb begin
    head_next = head_q;
    if (count_next == '0) begin
      head_next = '0;
    end else if (count_q == '0) begin
      head_next = push_data;
    end else if (pop_eff) begin
      if (count_q == CNT_W'(1)) begin
        head_next = push_data;
      end else begin
        head_next = mem[rd_ptr_inc];
      end
    end
  end

  // Pointer, occupancy and head registers; reset discards all contexts.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_inc;
      end
      count_q <= count_next;
      head_q  <= head_next;
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge aclk) begin
    if (push_eff) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = head_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_C);

endmodule

// File: rtl/segment_insert_scheduler.sv
// Segment insert scheduler.
//
// Looks up a per-requester insert configuration {seg, size, sel} at the
// start of every packet and queues it so the downstream inserter sees the
// configuration of the packet it is currently emitting. The upstream
// handshake is only gated for a start-of-packet beat when the context
// queue is full and not draining in the same cycle; beats inside a packet
// always pass.
//
// Ports:
//   aclk, areset              clock, asynchronous active-high reset
//   cfg_wr_en/id/seg/size/sel table write port (one entry per tuser ID)
//   s_tvalid/s_tlast/s_tuser  upstream beat qualifiers
//   s_tready                  upstream ready (inserter ready, gated)
//   ins_in_tvalid             valid toward the inserter input (gated)
//   ins_in_tready             inserter input ready
//   ins_out_tvalid/tready/tlast monitors of the inserter output handshake
//   seg_to_insert/segment_size/segment_sel  registered head-of-queue config
//   ctx_count/ctx_full        context queue occupancy status
module segment_insert_scheduler
  import segment_insert_pkg::*;
#(
  parameter int AXIS_USER_WIDTH  = DEF_AXIS_USER_WIDTH,
  parameter int MAX_INSRT_SIZE   = DEF_MAX_INSRT_SIZE,
  parameter int NUM_INSERT_SIZES = DEF_NUM_INSERT_SIZES,
  parameter int CTX_DEPTH        = DEF_CTX_DEPTH
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic                                  cfg_wr_en,
  input  logic [AXIS_USER_WIDTH-1:0]            cfg_id,
  input  logic [MAX_INSRT_SIZE*8-1:0]           cfg_seg,
  input  logic [size_width(MAX_INSRT_SIZE)-1:0] cfg_size,
  input  logic [sel_width(NUM_INSERT_SIZES)-1:0] cfg_sel,
  input  logic                                  s_tvalid,
  input  logic                                  s_tlast,
  input  logic [AXIS_USER_WIDTH-1:0]            s_tuser,
  output logic                                  s_tready,
  output logic                                  ins_in_tvalid,
  input  logic                                  ins_in_tready,
  input  logic                                  ins_out_tvalid,
  input  logic                                  ins_out_tready,
  input  logic                                  ins_out_tlast,
  output logic [MAX_INSRT_SIZE*8-1:0]           seg_to_insert,
  output logic [size_width(MAX_INSRT_SIZE)-1:0] segment_size,
  output logic [sel_width(NUM_INSERT_SIZES)-1:0] segment_sel,
  output logic [$clog2(CTX_DEPTH+1)-1:0]        ctx_count,
  output logic                                  ctx_full
);

  localparam int SEG_W   = MAX_INSRT_SIZE * 8;
  localparam int SIZE_W  = size_width(MAX_INSRT_SIZE);
  localparam int SEL_W   = sel_width(NUM_INSERT_SIZES);
  localparam int CTX_W   = SEG_W + SIZE_W + SEL_W;
  localparam int ENTRIES = 2 ** AXIS_USER_WIDTH;

  logic [CTX_W-1:0] table_q [ENTRIES];
  logic [CTX_W-1:0] cfg_word;
  logic [CTX_W-1:0] push_word;
  logic [CTX_W-1:0] head_word;
  logic             sop_q;
  logic             out_pop;
  logic             block;
  logic             accept;
  logic             push;

  assign cfg_word = {cfg_seg, cfg_size, cfg_sel};

  // Per-ID configuration table. Reset returns every entry to "insert
  // nothing" so an unconfigured requester passes through untouched.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      table_q[cfg_id] <= cfg_word;
    end
  end

  // A table write landing in the same cycle as the SOP lookup for the same
  // ID must win, otherwise the packet would pick up the stale entry.
  assign push_word = (cfg_wr_en && (cfg_id == s_tuser)) ? cfg_word
                                                        : table_q[s_tuser];

  // The inserter retiring a packet frees its context. Gating an SOP only
  // when the queue cannot also drain this cycle lets a full queue swap
  // one context for another without a bubble.
  assign out_pop       = ins_out_tvalid && ins_out_tready && ins_out_tlast;
  assign block         = sop_q && ctx_full && !out_pop;
  assign ins_in_tvalid = s_tvalid && !block;
  assign s_tready      = ins_in_tready && !block;
  assign accept        = s_tvalid && s_tready;
  assign push          = accept && sop_q;

  // Start-of-packet tracker: the beat after any accepted tlast (or after
  // reset) opens a new packet.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      sop_q <= 1'b1;
    end else if (accept) begin
      sop_q <= s_tlast;
    end
  end

  insert_ctx_fifo #(
    .WIDTH (CTX_W),
    .DEPTH (CTX_DEPTH)
  ) u_ctx_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (push),
    .push_data (push_word),
    .pop       (out_pop),
    .head_data (head_word),
    .count     (ctx_count),
    .full      (ctx_full)
  );

  assign seg_to_insert = head_word[CTX_W-1 -: SEG_W];
  assign segment_size  = head_word[SEL_W +: SIZE_W];
  assign segment_sel   = head_word[SEL_W-1:0];

endmodule

// File: tb/tb_segment_insert_scheduler.sv
// Directed self-checking bench for segment_insert_scheduler at default
// parameters (4-bit tuser, 4-byte segments, 2 inserter variants, 4 contexts).
module tb_segment_insert_scheduler;

  logic        aclk;
  logic        areset;
  logic        cfg_wr_en;
  logic [3:0]  cfg_id;
  logic [31:0] cfg_seg;
  logic [2:0]  cfg_size;
  logic [0:0]  cfg_sel;
  logic        s_tvalid;
  logic        s_tlast;
  logic [3:0]  s_tuser;
  logic        s_tready;
  logic        ins_in_tvalid;
  logic        ins_in_tready;
  logic        ins_out_tvalid;
  logic        ins_out_tready;
  logic        ins_out_tlast;
  logic [31:0] seg_to_insert;
  logic [2:0]  segment_size;
  logic [0:0]  segment_sel;
  logic [2:0]  ctx_count;
  logic        ctx_full;

  int errCount   = 0;
  int checkCount = 0;

  segment_insert_scheduler dut (
    .aclk           (aclk),
    .areset         (areset),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_id         (cfg_id),
    .cfg_seg        (cfg_seg),
    .cfg_size       (cfg_size),
    .cfg_sel        (cfg_sel),
    .s_tvalid       (s_tvalid),
    .s_tlast        (s_tlast),
    .s_tuser        (s_tuser),
    .s_tready       (s_tready),
    .ins_in_tvalid  (ins_in_tvalid),
    .ins_in_tready  (ins_in_tready),
    .ins_out_tvalid (ins_out_tvalid),
    .ins_out_tready (ins_out_tready),
    .ins_out_tlast  (ins_out_tlast),
    .seg_to_insert  (seg_to_insert),
    .segment_size   (segment_size),
    .segment_sel    (segment_sel),
    .ctx_count      (ctx_count),
    .ctx_full       (ctx_full)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] seg,
                           input logic [2:0] size, input logic sel,
                           input logic [2:0] cnt);
    checkOutput({tag, "_seg"},   64'(seg_to_insert), 64'(seg));
    checkOutput({tag, "_size"},  64'(segment_size),  64'(size));
    checkOutput({tag, "_sel"},   64'(segment_sel),   64'(sel));
    checkOutput({tag, "_count"}, 64'(ctx_count),     64'(cnt));
  endtask

  // Moves to 1 ns after the next rising edge; registered outputs are stable.
  task automatic stepClock();
    @(posedge aclk);
    #1;
  endtask

  // Drives one cycle's upstream beat and output-side tlast handshake, then
  // lets the combinational ready/valid gating settle.
  task automatic applyStimulus(input logic v, input logic l,
                               input logic [3:0] u, input logic op);
    s_tvalid       = v;
    s_tlast        = l;
    s_tuser        = u;
    ins_out_tvalid = op;
    ins_out_tready = op;
    ins_out_tlast  = op;
    #1;
  endtask

  task automatic writeCfg(input logic [3:0] id, input logic [31:0] seg,
                          input logic [2:0] size, input logic sel);
    cfg_wr_en = 1'b1;
    cfg_id    = id;
    cfg_seg   = seg;
    cfg_size  = size;
    cfg_sel   = sel;
    stepClock();
    cfg_wr_en = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    cfg_wr_en = 1'b0; cfg_id = '0; cfg_seg = '0; cfg_size = '0; cfg_sel = '0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
    ins_in_tready = 1'b1;
    ins_out_tvalid = 1'b0; ins_out_tready = 1'b0; ins_out_tlast = 1'b0;

    #12;
    checkHead("rst", 32'h0, 3'd0, 1'b0, 3'd0);
    checkOutput("rst_full", 64'(ctx_full), 64'd0);
    checkOutput("rst_tready", 64'(s_tready), 64'd1);
    areset = 1'b0;
    stepClock();

    // Single 3-beat packet for ID1.
    writeCfg(4'd1, 32'hDEADBEEF, 3'd4, 1'b1);
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b0);
    checkOutput("t1_sop_tready", 64'(s_tready), 64'd1);
    checkOutput("t1_sop_invalid", 64'(ins_in_tvalid), 64'd1);
    checkHead("t1_pre", 32'h0, 3'd0, 1'b0, 3'd0);
    stepClock();
    checkHead("t1_sop", 32'hDEADBEEF, 3'd4, 1'b1, 3'd1);
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 1'b1, 4'd1, 1'b0);
    stepClock();
    checkHead("t1_last", 32'hDEADBEEF, 3'd4, 1'b1, 3'd1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkHead("t1_pop", 32'h0, 3'd0, 1'b0, 3'd0);

    // Fill the queue with four 2-beat packets, IDs 0..3, nothing draining.
    writeCfg(4'd2, 32'h22222222, 3'd2, 1'b0);
    writeCfg(4'd3, 32'h33333333, 3'd3, 1'b1);
    for (int id = 0; id < 4; id++) begin
      applyStimulus(1'b1, 1'b0, 4'(id), 1'b0);
      stepClock();
      applyStimulus(1'b1, 1'b1, 4'(id), 1'b0);
      stepClock();
    end
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkHead("t2_full", 32'h0, 3'd0, 1'b0, 3'd4);
    checkOutput("t2_full_flag", 64'(ctx_full), 64'd1);
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b0);
    checkOutput("t2_sop_blocked_tready", 64'(s_tready), 64'd0);
    checkOutput("t2_sop_blocked_invalid", 64'(ins_in_tvalid), 64'd0);
    stepClock();
    checkOutput("t2_blocked_count", 64'(ctx_count), 64'd4);

    // Pop and SOP in the same cycle: SOP passes, occupancy unchanged.
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b1);
    checkOutput("t3_swap_tready", 64'(s_tready), 64'd1);
    stepClock();
    checkHead("t3_swap", 32'hDEADBEEF, 3'd4, 1'b1, 3'd4);

    // Mid-packet beat while full, with ID1 rewritten to size 0.
    cfg_wr_en = 1'b1; cfg_id = 4'd1; cfg_seg = 32'hDEADBEEF;
    cfg_size = 3'd0; cfg_sel = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'd1, 1'b0);
    checkOutput("t2_mid_tready", 64'(s_tready), 64'd1);
    checkOutput("t2_mid_full", 64'(ctx_full), 64'd1);
    stepClock();
    cfg_wr_en = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'd1, 1'b0);
    checkOutput("t2_last_tready", 64'(s_tready), 64'd1);
    stepClock();
    checkOutput("t2_end_count", 64'(ctx_count), 64'd4);

    // Drain one context per cycle; the queued ID1 packet keeps size 4.
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    stepClock();
    checkHead("t4_d1", 32'h22222222, 3'd2, 1'b0, 3'd3);
    stepClock();
    checkHead("t4_d2", 32'h33333333, 3'd3, 1'b1, 3'd2);
    stepClock();
    checkHead("t4_keep", 32'hDEADBEEF, 3'd4, 1'b1, 3'd1);
    stepClock();
    checkHead("t4_empty", 32'h0, 3'd0, 1'b0, 3'd0);
    // Spurious out tlast with nothing queued.
    stepClock();
    checkHead("t6_spurious", 32'h0, 3'd0, 1'b0, 3'd0);
    checkOutput("t6_full", 64'(ctx_full), 64'd0);

    // The next ID1 packet picks up the rewritten size.
    applyStimulus(1'b1, 1'b1, 4'd1, 1'b0);
    stepClock();
    checkHead("t4_new", 32'hDEADBEEF, 3'd0, 1'b1, 3'd1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    stepClock();
    checkHead("t4_drop", 32'h0, 3'd0, 1'b0, 3'd0);

    // Table write and SOP lookup of the same ID in one cycle.
    cfg_wr_en = 1'b1; cfg_id = 4'd2; cfg_seg = 32'hCAFEF00D;
    cfg_size = 3'd1; cfg_sel = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'd2, 1'b0);
    stepClock();
    cfg_wr_en = 1'b0;
    checkHead("t_fwd", 32'hCAFEF00D, 3'd1, 1'b1, 3'd1);

    // Second context, left mid-packet, then asynchronous reset.
    applyStimulus(1'b1, 1'b0, 4'd3, 1'b0);
    stepClock();
    checkHead("t5_pre", 32'hCAFEF00D, 3'd1, 1'b1, 3'd2);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    #2;
    areset = 1'b1;
    #1;
    checkHead("t5_async", 32'h0, 3'd0, 1'b0, 3'd0);
    checkOutput("t5_async_full", 64'(ctx_full), 64'd0);
    #2;
    areset = 1'b0;
    stepClock();

    // Former mid-packet beat is now an SOP; table was cleared to zero.
    applyStimulus(1'b1, 1'b0, 4'd3, 1'b0);
    checkOutput("t5_sop_tready", 64'(s_tready), 64'd1);
    stepClock();
    checkHead("t5_sop", 32'h0, 3'd0, 1'b0, 3'd1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    stepClock();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/segment_insert_scheduler.md
SEGMENT_INSERT_SCHEDULER -- requirements
Module: segment_insert_scheduler

Interface
REQ-001 SHALL have parameter AXIS_USER_WIDTH, default 4, meaning tuser width; tuser is the requester ID, giving 2**AXIS_USER_WIDTH table entries.
REQ-002 SHALL have parameter MAX_INSRT_SIZE, default 4, meaning largest insert segment in bytes.
REQ-003 SHALL have parameter NUM_INSERT_SIZES, default 2, meaning the number of selectable inserter FSM variants.
REQ-004 SHALL have parameter CTX_DEPTH, default 4, meaning the number of packet contexts in flight (power of 2).
REQ-005 SHALL have port aclk, input, 1, meaning the single clock.
REQ-006 SHALL have port areset, input, 1, meaning asynchronous active-high reset.
REQ-007 SHALL have port cfg_wr_en, input, 1, meaning table write strobe.
REQ-008 SHALL have port cfg_id, input, AXIS_USER_WIDTH, meaning the table entry written.
REQ-009 SHALL have port cfg_seg, input, MAX_INSRT_SIZE*8, meaning the segment bytes.
REQ-010 SHALL have port cfg_size, input, clog2(MAX_INSRT_SIZE+1), meaning the segment byte count.
REQ-011 SHALL have port cfg_sel, input, clog2(NUM_INSERT_SIZES), meaning the inserter FSM variant.
REQ-012 SHALL have ports s_tvalid (input, 1), s_tlast (input, 1), s_tuser (input, AXIS_USER_WIDTH) and s_tready (output, 1), meaning the upstream handshake.
REQ-013 SHALL have ports ins_in_tvalid (output, 1) and ins_in_tready (input, 1), meaning the gated handshake to the inserter input.
REQ-014 SHALL have ports ins_out_tvalid, ins_out_tready and ins_out_tlast, each input, 1, meaning monitors of the inserter output handshake.
REQ-015 SHALL have ports seg_to_insert, segment_size and segment_sel, outputs, with the cfg widths, meaning inserter configuration.
REQ-016 SHALL have ports ctx_count (output, clog2(CTX_DEPTH+1)) and ctx_full (output, 1), meaning context FIFO status.

Function
REQ-017 SHALL hold a config table of {seg, size, sel} per ID, written on the clock edge when cfg_wr_en=1.
REQ-018 SHALL track SOP with a register: set on reset, cleared on an accepted non-last beat, set on an accepted last beat; an accepted beat is s_tvalid && s_tready.
REQ-019 SHALL push table[s_tuser] into the context FIFO on each accepted beat while SOP=1.
REQ-020 SHALL pop the context FIFO on ins_out_tvalid && ins_out_tready && ins_out_tlast.
REQ-021 SHALL treat a simultaneous push and pop as one write and one read, leaving ctx_count unchanged; both are legal when full.
REQ-022 SHALL set ins_in_tvalid = s_tvalid && !block and s_tready = ins_in_tready && !block, where block = SOP && ctx_full && !pop.
REQ-023 SHALL never block a beat that is not an SOP beat.
REQ-024 SHALL drive seg_to_insert/segment_size/segment_sel from the FIFO head, registered, with zero combinational path from s_*.
REQ-025 SHALL drive all-zero config outputs when the FIFO is empty.
REQ-026 SHALL have a push-to-head latency of 1 cycle when the FIFO is empty, so config is valid no later than the inserter's first output beat.
REQ-027 SHALL capture table data at push, so a table write during a packet affects only later SOPs.
REQ-028 SHALL forward the new value when a table write and a push to the same ID occur in the same cycle.
REQ-029 SHALL ignore a pop while the FIFO is empty (no underflow, count stays 0).
REQ-030 SHALL set ctx_full exactly when ctx_count == CTX_DEPTH.
REQ-031 SHALL wrap the FIFO pointers modulo CTX_DEPTH.

Reset
REQ-032 SHALL, on areset, asynchronously clear the table to {0,0,0} (no insertion), empty the FIFO, set SOP=1, set ctx_count=0 and ctx_full=0, and zero the config outputs.
REQ-033 SHALL discard in-flight contexts on reset mid-packet; the first accepted beat after reset is treated as an SOP.

Structure
REQ-034 SHALL place the ctx_t struct {seg, size, sel} and the width localparams in package segment_insert_pkg.
REQ-035 SHALL implement the context FIFO as sub-module insert_ctx_fifo, a registered-head synchronous FIFO with count output.

Verification
REQ-036 SHALL test: table ID1={0xDEADBEEF,4,1}, single 3-beat packet tuser=1 -> outputs 0xDEADBEEF/4/1 from the cycle after SOP until the out tlast handshake, then zero.
REQ-037 SHALL test: back-to-back packets IDs 0,1,2,3 with out_tready=0 -> ctx_count reaches 4, ctx_full=1, and the 5th SOP sees s_tready=0 while its mid-packet beats still pass.
REQ-038 SHALL test: full FIFO with out tlast pop and new SOP in the same cycle -> SOP accepted and ctx_count stays 4.
REQ-039 SHALL test: rewrite ID1 to size 0 mid-packet -> the current packet keeps size 4 and the next ID1 packet gets size 0.
REQ-040 SHALL test: areset asserted with 2 contexts queued -> ctx_count=0 and outputs zero immediately (asynchronous), and the next beat is pushed as SOP.
REQ-041 SHALL test: spurious out tlast while empty -> ctx_count stays 0 and no state change.
